pipe_ctrl_bubble_reg: RTL and testbench

- Parametrised pipeline control register between the ID and EX stages. It carries the WB/MEM/EX control fields plus a valid bit.
- Supports three actions:
  - hold (stall)
  - single-cycle kill (flush)
  - a multi-cycle bubble train of programmable length for load-use and multi-cycle hazards
- Keeps a saturating count of injected bubbles for performance observation.
- Replaces the combinational zeroing mux plus a plain pipeline register with one sequential block.

---
 rtl/pipe_ctrl_bubble_reg.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl_bubble_reg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_bubble_reg.sv
// ID/EX pipeline control register with stall, flush and programmable bubble trains.
// Also keeps a saturating count of injected bubbles for performance observation.
module pipe_ctrl_bubble_reg #(
    parameter int unsigned WB_W  = 2,
    parameter int unsigned MEM_W = 2,
    parameter int unsigned EX_W  = 4,
    parameter int unsigned LEN_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             bubble_req_i,
    input  logic [LEN_W-1:0] bubble_len_i,
    input  logic             valid_i,
    input  logic [WB_W-1:0]  WB_i,
    input  logic [MEM_W-1:0] MEM_i,
    input  logic [EX_W-1:0]  EX_i,
    output logic             valid_o,
    output logic [WB_W-1:0]  WB_o,
    output logic [MEM_W-1:0] MEM_o,
    output logic [EX_W-1:0]  EX_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;      // bubbles still owed after the current one
    logic [LEN_W-1:0] rem_d;
    logic             hold_c;
    logic             load_bubble_c;

    // Next-state and action decode: flush beats stall beats the state action.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        hold_c        = 1'b0;
        load_bubble_c = 1'b0;
        if (flush_i) begin
            load_bubble_c = 1'b1;
            state_d       = IDLE;
            rem_d         = '0;
        end else if (stall_i) begin
            hold_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero-length request is treated as no request.
                    if (bubble_req_i && (bubble_len_i != '0)) begin
                        load_bubble_c = 1'b1;
                        rem_d         = bubble_len_i - LEN_W'(1);
                        state_d       = (bubble_len_i > LEN_W'(1)) ? BUBBLE : IDLE;
                    end
                end
                BUBBLE: begin
                    load_bubble_c = 1'b1;
                    // rem of 0 cannot occur in BUBBLE; treat it like the last bubble.
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // State, remaining-count and busy registers; busy mirrors the registered state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_o  <= (state_d == BUBBLE);
        end
    end

    // Control payload register: bubble zeroes everything, stall holds, else pass through.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            WB_o    <= '0;
            MEM_o   <= '0;
            EX_o    <= '0;
        end else if (load_bubble_c) begin
            valid_o <= 1'b0;
            WB_o    <= '0;
            MEM_o   <= '0;
            EX_o    <= '0;
        end else if (!hold_c) begin
            valid_o <= valid_i;
            WB_o    <= WB_i;
            MEM_o   <= MEM_i;
            EX_o    <= EX_i;
        end
    end

    // Saturating count of bubble-loading edges.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (load_bubble_c && (bubble_cnt_o != '1)) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_bubble_reg.sv
// Directed bench for pipe_ctrl_bubble_reg: pass, trains, stall, flush, saturation, async reset.
module tb_pipe_ctrl_bubble_reg;

    localparam int unsigned LEN_W = 3;

    // Packed {valid, WB, MEM, EX} expectations
    localparam logic [31:0] P_A   = 32'h19A;   // 1, 2'b10, 2'b01, 4'hA
    localparam logic [31:0] P_B   = 32'h065;   // 0, 2'b01, 2'b10, 4'h5
    localparam logic [31:0] P_0   = 32'h000;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             bubble_req;
    logic [LEN_W-1:0] bubble_len;
    logic             valid_in;
    logic [1:0]       wb_in;
    logic [1:0]       mem_in;
    logic [3:0]       ex_in;

    logic             valid_out;
    logic [1:0]       wb_out;
    logic [1:0]       mem_out;
    logic [3:0]       ex_out;
    logic             busy;
    logic [15:0]      cnt;

    logic             s_valid_out;
    logic [1:0]       s_wb_out;
    logic [1:0]       s_mem_out;
    logic [3:0]       s_ex_out;
    logic             s_busy;
    logic [3:0]       s_cnt;

    logic [8:0]       out_pk;
    assign out_pk = {valid_out, wb_out, mem_out, ex_out};

    int checks   = 0;
    int failures = 0;

    pipe_ctrl_bubble_reg dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .stall_i      (stall),
        .flush_i      (flush),
        .bubble_req_i (bubble_req),
        .bubble_len_i (bubble_len),
        .valid_i      (valid_in),
        .WB_i         (wb_in),
        .MEM_i        (mem_in),
        .EX_i         (ex_in),
        .valid_o      (valid_out),
        .WB_o         (wb_out),
        .MEM_o        (mem_out),
        .EX_o         (ex_out),
        .busy_o       (busy),
        .bubble_cnt_o (cnt)
    );

    pipe_ctrl_bubble_reg #(.CNT_W(4)) dut_sat (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .stall_i      (stall),
        .flush_i      (flush),
        .bubble_req_i (bubble_req),
        .bubble_len_i (bubble_len),
        .valid_i      (valid_in),
        .WB_i         (wb_in),
        .MEM_i        (mem_in),
        .EX_i         (ex_in),
        .valid_o      (s_valid_out),
        .WB_o         (s_wb_out),
        .MEM_o        (s_mem_out),
        .EX_o         (s_ex_out),
        .busy_o       (s_busy),
        .bubble_cnt_o (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] w, input logic [1:0] m, input logic [3:0] e);
        valid_in = v;
        wb_in    = w;
        mem_in   = m;
        ex_in    = e;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_state(input string tag, input logic [31:0] o, input logic b, input logic [31:0] c);
        check({tag, "_out"}, 32'(out_pk), o);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_cnt"}, 32'(cnt), c);
    endtask

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        bubble_req = 1'b0;
        bubble_len = '0;
        set_in(1'b0, 2'b00, 2'b00, 4'h0);
        tick();
        tick();
        check_state("reset", P_0, 1'b0, 0);
        check("reset_sat_cnt", 32'(s_cnt), 0);

        // Pass-through
        rst_n = 1'b1;
        set_in(1'b1, 2'b10, 2'b01, 4'hA);
        tick();
        check_state("pass", P_A, 1'b0, 0);

        // Stall in IDLE holds outputs; request during stall is dropped
        stall = 1'b1; bubble_req = 1'b1; bubble_len = 3'd2;
        set_in(1'b0, 2'b01, 2'b10, 4'h5);
        tick();
        check_state("idle_stall", P_A, 1'b0, 0);
        stall = 1'b0; bubble_req = 1'b0;
        tick();
        check_state("pass_invalid", P_B, 1'b0, 0);

        // Train of 3
        set_in(1'b1, 2'b10, 2'b01, 4'hA);
        bubble_req = 1'b1; bubble_len = 3'd3;
        tick();
        check_state("tr3_b1", P_0, 1'b1, 1);
        bubble_req = 1'b0;
        tick();
        check_state("tr3_b2", P_0, 1'b1, 2);
        tick();
        check_state("tr3_b3", P_0, 1'b0, 3);
        tick();
        check_state("tr3_pass", P_A, 1'b0, 3);

        // Train of 4 with a 2-cycle stall after the first bubble
        apply_reset();
        bubble_req = 1'b1; bubble_len = 3'd4;
        tick();
        check_state("tr4_b1", P_0, 1'b1, 1);
        bubble_req = 1'b0; stall = 1'b1;
        tick();
        check_state("tr4_st1", P_0, 1'b1, 1);
        tick();
        check_state("tr4_st2", P_0, 1'b1, 1);
        stall = 1'b0;
        tick();
        check_state("tr4_b2", P_0, 1'b1, 2);
        tick();
        check_state("tr4_b3", P_0, 1'b1, 3);
        tick();
        check_state("tr4_b4", P_0, 1'b0, 4);
        tick();
        check_state("tr4_pass", P_A, 1'b0, 4);

        // Flush with stall during the 2nd bubble of a length-5 train
        apply_reset();
        bubble_req = 1'b1; bubble_len = 3'd5;
        tick();
        check_state("fl_b1", P_0, 1'b1, 1);
        bubble_req = 1'b0;
        tick();
        check_state("fl_b2", P_0, 1'b1, 2);
        flush = 1'b1; stall = 1'b1;
        tick();
        check_state("fl_kill", P_0, 1'b0, 3);
        flush = 1'b0; stall = 1'b0;
        tick();
        check_state("fl_pass", P_A, 1'b0, 3);
        flush = 1'b1;
        tick();
        check_state("fl_idle", P_0, 1'b0, 4);
        flush = 1'b0;

        // Zero-length request is a plain pass; length 1 is one bubble without busy
        bubble_req = 1'b1; bubble_len = 3'd0;
        tick();
        check_state("len0", P_A, 1'b0, 4);
        bubble_len = 3'd1;
        tick();
        check_state("len1_b", P_0, 1'b0, 5);
        bubble_req = 1'b0;
        tick();
        check_state("len1_pass", P_A, 1'b0, 5);

        // Saturation on the narrow counter: 20 flush bubbles
        apply_reset();
        flush = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("sat15", 32'(s_cnt), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b0;
        check("sat20", 32'(s_cnt), 32'hF);
        check("wide20", 32'(cnt), 20);

        // Async reset mid-train
        bubble_req = 1'b1; bubble_len = 3'd7;
        tick();
        bubble_req = 1'b0;
        tick();
        check_state("pre_rst", P_0, 1'b1, 22);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_rst", P_0, 1'b0, 0);
        check("async_rst_sat", 32'(s_cnt), 0);
        check("async_rst_sbusy", 32'(s_busy), 0);

        // Async reset clears passed-through payload between edges
        rst_n = 1'b1;
        tick();
        check("pre_rst2", 32'(out_pk), P_A);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst2", 32'(out_pk), P_0);
        check("async_rst2_s", 32'({s_valid_out, s_wb_out, s_mem_out, s_ex_out}), P_0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
